// File: rtl/sd_spi_responder_if.sv
// sd_spi_responder_if: SPI pins plus host-side block buffer port
// for the SD SPI-mode responder.
interface sd_spi_responder_if;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       buf_we;
  logic [8:0] buf_addr;
  logic [7:0] buf_wdata;
  logic [7:0] buf_rdata;

  modport master (
    output cs,
    output sclk,
    output mosi,
    output buf_we,
    output buf_addr,
    output buf_wdata,
    input  miso,
    input  buf_rdata
  );

  modport slave (
    input  cs,
    input  sclk,
    input  mosi,
    input  buf_we,
    input  buf_addr,
    input  buf_wdata,
    output miso,
    output buf_rdata
  );
endinterface

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SD-card SPI-mode responder (CMD0/41/17/24)
// backed by a single block buffer shared with a host port.
module sd_spi_responder #(
  parameter int BLOCK_BYTES  = 512,
  parameter int NCR_BYTES    = 1,
  parameter int ACCESS_BYTES = 2,
  parameter int BUSY_BYTES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  sd_spi_responder_if.slave bus,
  output logic [5:0]        last_cmd,
  output logic [31:0]       last_arg,
  output logic              busy
);

  localparam logic [8:0] LAST  = 9'(BLOCK_BYTES - 1);
  localparam logic [7:0] NCR_L = 8'(NCR_BYTES - 1);
  localparam logic [7:0] ACC_L = 8'(ACCESS_BYTES - 1);
  localparam logic [7:0] BSY_L = 8'(BUSY_BYTES - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_NCR,
    ST_R1,
    ST_ACCESS,
    ST_RTOKEN,
    ST_RDATA,
    ST_RCRC,
    ST_WTOKEN,
    ST_WDATA,
    ST_WCRC,
    ST_DRESP,
    ST_WBUSY
  } state_t;

  state_t      state;
  logic        cs_m, cs_s;
  logic        sclk_m, sclk_s, sclk_d;
  logic        mosi_m, mosi_s;
  logic        sclk_rise, sclk_fall;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_byte;
  logic        byte_done;
  logic [7:0]  tx_sr;
  logic        miso_q;
  logic [7:0]  gap_cnt;
  logic [8:0]  byte_cnt;
  logic [5:0]  cmd_idx;
  logic [31:0] arg_sr;
  logic        idle_flag;
  logic [7:0]  r1_q;
  logic        rd_go, wr_go;

  logic        is0, is41, is17, is24;
  logic        idle_nx, illegal;
  logic [7:0]  r1_nx;

  logic [7:0]  mem [BLOCK_BYTES];
  logic [8:0]  rd_addr;
  logic [7:0]  spi_q;
  logic        spi_we;
  logic [7:0]  rdata_q;

  assign bus.miso      = miso_q;
  assign bus.buf_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_m   <= 1'b1;
      cs_s   <= 1'b1;
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      mosi_m <= 1'b1;
      mosi_s <= 1'b1;
    end else begin
      cs_m   <= bus.cs;
      cs_s   <= cs_m;
      sclk_m <= bus.sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      mosi_m <= bus.mosi;
      mosi_s <= mosi_m;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign rx_byte   = {rx_sr[6:0], mosi_s};
  assign byte_done = sclk_rise & (bit_cnt == 3'd7);

  always_comb begin
    is0  = cmd_idx == 6'd0;
    is41 = cmd_idx == 6'd41;
    is17 = cmd_idx == 6'd17;
    is24 = cmd_idx == 6'd24;
    idle_nx = idle_flag;
    unique case (1'b1)
      is0:     idle_nx = 1'b1;
      is41:    idle_nx = 1'b0;
      default: idle_nx = idle_flag;
    endcase
    illegal = ~(is0 | is41 | is17 | is24)
            | ((is17 | is24) & idle_nx);
    r1_nx = {5'b0, illegal, 1'b0, idle_nx};
  end

  // Next read byte is prefetched while the current one shifts out.
  always_comb begin
    rd_addr = '0;
    if (state == ST_RDATA && byte_cnt != LAST)
      rd_addr = byte_cnt + 9'd1;
  end

  assign spi_we = byte_done & ~rst & ~cs_s
                & (state == ST_WDATA);

  always_ff @(posedge clk) begin
    if (spi_we)
      mem[byte_cnt] <= rx_byte;
    else if (bus.buf_we)
      mem[bus.buf_addr] <= bus.buf_wdata;
    spi_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[bus.buf_addr];
  end

  always_ff @(posedge clk) begin
    if (rst || cs_s) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= 8'hFF;
      miso_q   <= 1'b1;
      busy     <= 1'b0;
      if (rst) begin
        last_cmd  <= '0;
        last_arg  <= '0;
        idle_flag <= 1'b1;
        cmd_idx   <= '0;
        arg_sr    <= '0;
        r1_q      <= 8'hFF;
        rd_go     <= 1'b0;
        wr_go     <= 1'b0;
      end
    end else begin
      if (sclk_fall) begin
        miso_q <= tx_sr[7];
        tx_sr  <= {tx_sr[6:0], 1'b1};
      end
      if (sclk_rise) begin
        rx_sr   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        tx_sr <= 8'hFF;
        unique case (state)
          ST_IDLE: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd_idx <= rx_byte[5:0];
              gap_cnt <= '0;
              state   <= ST_CMD;
            end
          end
          ST_CMD: begin
            if (gap_cnt == 8'd4) begin
              gap_cnt   <= '0;
              busy      <= 1'b1;
              last_cmd  <= cmd_idx;
              last_arg  <= arg_sr;
              idle_flag <= idle_nx;
              r1_q      <= r1_nx;
              rd_go     <= is17 & ~illegal;
              wr_go     <= is24 & ~illegal;
              if (NCR_BYTES == 0) begin
                tx_sr <= r1_nx;
                state <= ST_R1;
              end else begin
                state <= ST_NCR;
              end
            end else begin
              arg_sr  <= {arg_sr[23:0], rx_byte};
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          ST_NCR: begin
            if (gap_cnt == NCR_L) begin
              gap_cnt <= '0;
              tx_sr   <= r1_q;
              state   <= ST_R1;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          ST_R1: begin
            if (rd_go) begin
              if (ACCESS_BYTES == 0) begin
                tx_sr <= 8'hFE;
                state <= ST_RTOKEN;
              end else begin
                state <= ST_ACCESS;
              end
            end else if (wr_go) begin
              state <= ST_WTOKEN;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          ST_ACCESS: begin
            if (gap_cnt == ACC_L) begin
              gap_cnt <= '0;
              tx_sr   <= 8'hFE;
              state   <= ST_RTOKEN;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          ST_RTOKEN: begin
            byte_cnt <= '0;
            tx_sr    <= spi_q;
            state    <= ST_RDATA;
          end
          ST_RDATA: begin
            if (byte_cnt == LAST) begin
              byte_cnt <= '0;
              gap_cnt  <= '0;
              state    <= ST_RCRC;
            end else begin
              byte_cnt <= byte_cnt + 9'd1;
              tx_sr    <= spi_q;
            end
          end
          ST_RCRC: begin
            if (gap_cnt == 8'd1) begin
              gap_cnt <= '0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          ST_WTOKEN: begin
            if (rx_byte == 8'hFE) begin
              byte_cnt <= '0;
              state    <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (byte_cnt == LAST) begin
              byte_cnt <= '0;
              gap_cnt  <= '0;
              state    <= ST_WCRC;
            end else begin
              byte_cnt <= byte_cnt + 9'd1;
            end
          end
          ST_WCRC: begin
            if (gap_cnt == 8'd1) begin
              gap_cnt <= '0;
              tx_sr   <= 8'h05;
              state   <= ST_DRESP;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
          ST_DRESP: begin
            gap_cnt <= '0;
            if (BUSY_BYTES == 0) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              tx_sr <= 8'h00;
              state <= ST_WBUSY;
            end
          end
          ST_WBUSY: begin
            if (gap_cnt == BSY_L) begin
              gap_cnt <= '0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
              tx_sr   <= 8'h00;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
